cam_access_arbiter: RTL and testbench

- Shares the 4-entry associative memory (4-bit address tag, 4-bit data) between two requesters.
- Per-requester req/ack handshake; round-robin arbitration; sequences each read or write into the memory's single clk/wr/Address/Data_in port.
- Captures the memory's registered Data_out/Hit and returns it to the granted requester.
- Parks the memory on a reserved address when idle, so idle cycles cannot disturb usage counters on live tags.

---
 rtl/cam_access_arbiter.sv | 148 ++++++++++++++
 tb/tb_cam_access_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cam_access_arbiter.sv
// Two-requester round-robin front end for the 4-entry CAM's single command port.
// Optional read hit/miss counters are enabled by defining CAM_ACCESS_STATS_EN.
module cam_access_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int MEM_LAT = 1,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_hit,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_hit,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_hit,
  output logic              busy
`ifdef CAM_ACCESS_STATS_EN
  ,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

  localparam logic [1:0] CNT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  state_t            state, next_state;
  logic [1:0]        cnt;
  logic              cmd_wr, cmd_id, last_grant;
  logic              any_req, grant_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              mem_wr_d, ack0_d, ack1_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // Under contention the requester not served last wins; a lone request wins outright.
  assign any_req   = r0_req | r1_req;
  assign grant_id  = (r0_req & r1_req) ? ~last_grant : r1_req;
  assign sel_wr    = grant_id ? r1_wr    : r0_wr;
  assign sel_addr  = grant_id ? r1_addr  : r0_addr;
  assign sel_wdata = grant_id ? r1_wdata : r0_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = (MEM_LAT > 1) ? WAIT : CAPTURE;
      WAIT:    if (cnt == 2'd0) next_state = CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values for the registered outputs; the memory port only leaves the
  // parking address for the single ISSUE cycle.
  always_comb begin
    mem_wr_d    = 1'b0;
    mem_addr_d  = IDLE_ADDR;
    mem_wdata_d = '0;
    if (state == IDLE && any_req) begin
      mem_wr_d    = sel_wr;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
    end
    ack0_d = (state == CAPTURE) && !cmd_id;
    ack1_d = (state == CAPTURE) && cmd_id;
    busy_d = (next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr     <= 1'b0;
      mem_addr   <= IDLE_ADDR;
      mem_wdata  <= '0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      r0_hit     <= 1'b0;
      r1_hit     <= 1'b0;
      busy       <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_id     <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 2'd0;
    end else begin
      mem_wr    <= mem_wr_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      r0_ack    <= ack0_d;
      r1_ack    <= ack1_d;
      busy      <= busy_d;
      if (state == IDLE && any_req) begin
        cmd_wr     <= sel_wr;
        cmd_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == ISSUE)     cnt <= CNT_INIT;
      else if (state == WAIT) cnt <= cnt - 2'd1;
      // Writes return zeroed data/hit so a stale read result is never re-acked.
      if (state == CAPTURE) begin
        if (!cmd_id) begin
          r0_rdata <= cmd_wr ? '0 : mem_rdata;
          r0_hit   <= !cmd_wr && mem_hit;
        end else begin
          r1_rdata <= cmd_wr ? '0 : mem_rdata;
          r1_hit   <= !cmd_wr && mem_hit;
        end
      end
    end
  end

`ifdef CAM_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 8'd0;
      miss_cnt <= 8'd0;
    end else if (state == CAPTURE && !cmd_wr) begin
      if (mem_hit && hit_cnt != 8'hFF)   hit_cnt  <= hit_cnt + 8'd1;
      if (!mem_hit && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cam_access_arbiter.sv
// Directed bench for cam_access_arbiter with a behavioural CAM of configurable latency.
module tb_cam_access_arbiter;
`ifdef CAM_ACCESS_STATS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       r0_req = 0, r0_wr = 0, r1_req = 0, r1_wr = 0;
  logic [3:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic       r0_ack, r0_hit, r1_ack, r1_hit, mem_wr, mem_hit, busy;
  logic [3:0] r0_rdata, r1_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef CAM_ACCESS_STATS_EN
  logic [7:0] hit_cnt, miss_cnt;
`endif

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  cam_access_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_hit(r0_hit),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_hit(r1_hit),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_hit(mem_hit), .busy(busy)
`ifdef CAM_ACCESS_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // CAM model: tag-indexed store, registered output delayed LAT cycles.
  logic [3:0] cam_d [16];
  logic       cam_v [16];
  logic [3:0] pd [4];
  logic       ph [4];
  initial for (int i = 0; i < 16; i++) begin cam_d[i] = 0; cam_v[i] = 0; end
  initial for (int i = 0; i < 4; i++) begin pd[i] = 0; ph[i] = 0; end
  always @(posedge clk) begin
    if (mem_wr) begin cam_d[mem_addr] <= mem_wdata; cam_v[mem_addr] <= 1'b1; end
    pd[0] <= cam_v[mem_addr] ? cam_d[mem_addr] : 4'h0;
    ph[0] <= cam_v[mem_addr];
    for (int k = 1; k < 4; k++) begin pd[k] <= pd[k-1]; ph[k] <= ph[k-1]; end
  end
  assign mem_rdata = pd[LAT-1];
  assign mem_hit   = ph[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one command from requester id in the current cycle (cycle 0) and follow it to ack.
  task automatic txn(input int id, input logic wr, input logic [3:0] a, input logic [3:0] d,
                     input logic [3:0] exp_rd, input logic exp_hit);
    int n = 0;
    logic got = 0;
    if (id == 0) begin r0_req = 1; r0_wr = wr; r0_addr = a; r0_wdata = d; end
    else         begin r1_req = 1; r1_wr = wr; r1_addr = a; r1_wdata = d; end
    while (n < 20 && !got) begin
      step(); n++;
      if (n == 1) begin
        chk("issue_wr", mem_wr, wr);
        chk("issue_addr", mem_addr, a);
      end else if (n == 2) begin
        chk("post_issue_wr", mem_wr, 0);
        chk("post_issue_addr", mem_addr, 4'hF);
      end
      chk("other_ack", (id == 0) ? r1_ack : r0_ack, 0);
      got = (id == 0) ? r0_ack : r1_ack;
    end
    chk("ack_lat", n, 2 + LAT);
    chk("rdata", (id == 0) ? r0_rdata : r1_rdata, exp_rd);
    chk("hit", (id == 0) ? r0_hit : r1_hit, exp_hit);
    r0_req = 0; r1_req = 0;
    step();
    chk("ack_pulse", (id == 0) ? r0_ack : r1_ack, 0);
    chk("rdata_hold", (id == 0) ? r0_rdata : r1_rdata, exp_rd);
  endtask

  initial begin
    int c, nack;
    int ids[4], cyc[4];

    // Reset and park
    rst = 1; step(); step(); rst = 0;
    chk("rst_addr", mem_addr, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", r0_rdata, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_wr", mem_wr, 0);
      chk("idle_addr", mem_addr, 4'hF);
      chk("idle_busy", busy, 0);
      chk("idle_ack", {r0_ack, r1_ack}, 0);
    end

    // Write then read back; read of unwritten tag from r1
    txn(0, 1, 4'h3, 4'hA, 4'h0, 0);
    txn(0, 0, 4'h3, 4'h0, 4'hA, 1);
    txn(1, 0, 4'h7, 4'h0, 4'h0, 0);
    chk("r0_rdata_kept", r0_rdata, 4'hA);

    // Contention from reset: r0 read 3 (hit A), r1 read 7 (miss), both held
    rst = 1; step(); rst = 0;
    r0_req = 1; r0_wr = 0; r0_addr = 4'h3;
    r1_req = 1; r1_wr = 0; r1_addr = 4'h7;
    c = 0; nack = 0;
    while (c < 60 && nack < 4) begin
      step(); c++;
      if (r0_ack && r1_ack) chk("dual_ack", 1, 0);
      else if (r0_ack || r1_ack) begin
        ids[nack] = r1_ack ? 1 : 0;
        cyc[nack] = c;
        chk("rr_data", r1_ack ? r1_rdata : r0_rdata, r1_ack ? 4'h0 : 4'hA);
        nack++;
      end
    end
    r0_req = 0; r1_req = 0;
    chk("rr_count", nack, 4);
    for (int k = 0; k < nack; k++) begin
      chk("rr_id", ids[k], k % 2);
      chk("rr_cyc", cyc[k], 2 + LAT + k * (3 + LAT));
    end
    step(); step();

    // Reset during r1 write's ISSUE cycle
    r1_req = 1; r1_wr = 1; r1_addr = 4'h5; r1_wdata = 4'h6;
    step();
    chk("rstw_issue", {mem_wr, mem_addr}, {1'b1, 4'h5});
    rst = 1; r1_req = 0;
    step();
    rst = 0;
    chk("rstw_busy", busy, 0);
    chk("rstw_park", {mem_wr, mem_addr}, {1'b0, 4'hF});
    for (int i = 0; i < 4; i++) begin
      chk("rstw_no_ack", r1_ack, 0);
      step();
    end
    // Write was still sampled by the memory
    txn(0, 0, 4'h5, 4'h0, 4'h6, 1);

`ifdef CAM_ACCESS_STATS_EN
    rst = 1; step(); rst = 0;
    chk("stat_rst", {hit_cnt, miss_cnt}, 0);
    txn(0, 0, 4'h3, 4'h0, 4'hA, 1);
    txn(1, 0, 4'h5, 4'h0, 4'h6, 1);
    txn(0, 0, 4'h7, 4'h0, 4'h0, 0);
    txn(1, 1, 4'h9, 4'h1, 4'h0, 0);
    txn(0, 0, 4'h3, 4'h0, 4'hA, 1);
    txn(1, 0, 4'h8, 4'h0, 4'h0, 0);
    chk("hit_cnt", hit_cnt, 3);
    chk("miss_cnt", miss_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
